led_ctrl_axil_slave: RTL and testbench
======================================

// Module: led_ctrl_axil_slave
// PURPOSE
//  AXI4-Lite responder for the LED controller IP; the completer the master VIP drives in simulation.
//  Holds four 32-bit software registers, fully readable back, and drives the LED pins from them.
//  LEDs are static or blinking. Sits between the AXI interconnect and the board LED pins.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  4   address width; addr[3:2] selects the register.
//  NUM_LEDS            4   LED output width, 1..32.
// PORTS
//  S_AXI_ACLK     in   1        single clock for the whole block.
//  S_AXI_ARESETN  in   1        reset; synchronous, active-low.
//  S_AXI_AWADDR   in   ADDR_W   write address.        S_AXI_AWPROT in 3  ignored.
//  S_AXI_AWVALID  in   1        write address valid.   S_AXI_AWREADY out 1.
//  S_AXI_WDATA    in   32       write data.            S_AXI_WSTRB in 4  byte enables.
//  S_AXI_WVALID   in   1        write data valid.      S_AXI_WREADY out 1.
//  S_AXI_BRESP    out  2        always 2'b00 (OKAY).   S_AXI_BVALID out 1; S_AXI_BREADY in 1.
//  S_AXI_ARADDR   in   ADDR_W   read address.          S_AXI_ARPROT in 3  ignored.
//  S_AXI_ARVALID  in   1        read address valid.    S_AXI_ARREADY out 1.
//  S_AXI_RDATA    out  32       read data.             S_AXI_RRESP out 2  always OKAY.
//  S_AXI_RVALID   out  1        read data valid.       S_AXI_RREADY in 1.
//  led            out  NUM_LEDS LED drive, registered.
// BEHAVIOUR
//  Register map (all RW, reset 0): 0x0 LED_VAL, 0x4 MODE (bit0: 0=static, 1=blink),
//   0x8 PERIOD (half-period in clocks; 0 is treated as 1), 0xC SCRATCH.
//  Reset (ARESETN=0 at a clock edge): AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, RDATA=0, led=0,
//   and all registers, the blink counter and the phase bit cleared.
//   A reset mid-transaction drops that transaction; no response is issued afterwards.
//  Write channel, at most one write outstanding:
//   - AW and W are captured independently. AWREADY/WREADY each pulse for one cycle when that
//     channel's VALID is high, its holding slot is empty and BVALID=0.
//   - Once both the address and the data are held, the register is updated on the next edge with
//     per-byte WSTRB merge, and BVALID is raised on that same edge.
//   - BVALID stays high until BREADY. The slots are freed in the cycle BREADY is sampled.
//   - Write-to-B latency is 2 clocks when AW and W arrive together.
//  Read channel, independent of writes:
//   - ARREADY pulses for 1 cycle when ARVALID=1 and RVALID=0.
//   - RDATA and RVALID register on the next edge, so latency is 1 clock. The slave accepts no new AR
//     until RVALID&RREADY.
//   - RDATA is held stable while RVALID=1 and RREADY=0.
//  A read and a write to the same register in the same cycle return the old value; the write lands
//   after.
//  Addresses use addr[3:2] only; upper and lower bits are ignored, so aliases wrap.
//  Blink:
//   - In MODE.bit0=1 a counter runs 0..max(PERIOD,1)-1. On wrap, the phase bit toggles.
//   - led = LED_VAL[NUM_LEDS-1:0] & {NUM_LEDS{phase}}.
//   - A write to PERIOD or MODE clears the counter and sets phase=1 in the cycle after the write.
//  MODE.bit0=0: led = LED_VAL[NUM_LEDS-1:0] one cycle after the write commits; the counter is held at 0.
// STRUCTURE
//  Package led_ctrl_pkg holds:
//   - register offsets (LED_VAL_OFS..SCRATCH_OFS) and the 2-bit register index type;
//   - mode_e {MODE_STATIC, MODE_BLINK};
//   - AXI_RESP_OKAY.
//  Sub-module led_blink_gen (clk, resetn, enable, period, restart -> phase) owns the counter and
//   phase bit.
//  Top level contains the AXI write and read FSMs, the register file and the output mux.
//  Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
//  Read FSM states: R_IDLE, R_VALID.
// TESTING
//  1. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read them back -> each RDATA matches, BRESP and
//     RRESP are 0.
//  2. AWVALID 3 cycles before WVALID, then the reverse order -> one write each; BVALID 1 clk after
//     the later handshake.
//  3. WSTRB=4'b0010, WDATA=0xAABBCCDD to SCRATCH=0x11223344 -> reads back 0x1122CC44.
//  4. BREADY held low for 5 clks -> BVALID stays high; a second AW is not accepted until B completes.
//  5. LED_VAL=0xF, PERIOD=3, MODE=1 -> led toggles 0xF/0x0 every 3 clks. PERIOD=0 -> toggles every clk.
//  6. ARESETN low for 1 clk with BVALID pending -> all outputs 0, regs read 0, no stale B after
//     release.

Source files
------------

// File: rtl/led_ctrl_axil_slave_pkg.sv
// Shared definitions for the LED controller AXI4-Lite slave: register map,
// mode encoding, bus response codes, FSM state types and small helpers.
package led_ctrl_pkg;

    // Byte offsets of the four software registers
    localparam logic [3:0] LED_VAL_OFS = 4'h0;
    localparam logic [3:0] MODE_OFS    = 4'h4;
    localparam logic [3:0] PERIOD_OFS  = 4'h8;
    localparam logic [3:0] SCRATCH_OFS = 4'hC;

    // Register index is the word address, i.e. offset bits [3:2]
    typedef logic [1:0] reg_idx_t;

    localparam reg_idx_t LED_VAL_IDX = LED_VAL_OFS[3:2];
    localparam reg_idx_t MODE_IDX    = MODE_OFS[3:2];
    localparam reg_idx_t PERIOD_IDX  = PERIOD_OFS[3:2];
    localparam reg_idx_t SCRATCH_IDX = SCRATCH_OFS[3:2];

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_BLINK  = 1'b1
    } mode_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_VALID
    } rd_state_e;

    // Only bits [3:2] select a register; everything else aliases
    function automatic reg_idx_t ofs_to_idx(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

    // Per-byte merge of new write data into the current register value
    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_ctrl_axil_slave_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the LED
// controller register block (slave).
interface led_ctrl_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/led_ctrl_axil_slave_blink.sv
// Blink timebase: counts half-periods and flips the phase bit at each wrap.
// A restart pulse realigns the pattern so the LEDs come on immediately.
module led_blink_gen (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] period,
    input  logic        restart,
    output logic        phase
);
    logic [31:0] cnt;
    logic [31:0] last_cnt;

    // A period of 0 behaves like 1, so the last count value is never negative
    assign last_cnt = (period == 32'd0) ? 32'd0 : period - 32'd1;

    // Counter and phase: restart wins, static mode parks the counter at 0
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!enable) begin
            cnt   <= '0;
        end else if (cnt >= last_cnt) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 32'd1;
        end
    end
endmodule

// File: rtl/led_ctrl_axil_slave.sv
// AXI4-Lite slave for the LED controller: four RW registers (LED_VAL, MODE,
// PERIOD, SCRATCH), independent write/read FSMs and a registered LED output
// that is either static or gated by the blink phase.
module led_ctrl_axil_slave
    import led_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 4
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    led_ctrl_axil_slave_if.slave s_axi,
    output logic [NUM_LEDS-1:0]  led
);
    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;

    wr_state_e wr_state, wr_state_nxt;
    rd_state_e rd_state, rd_state_nxt;

    logic     aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic     aw_hs, w_hs, ar_hs, commit;
    reg_idx_t aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;

    mode_e cur_mode;
    logic  blink_restart;
    logic  phase;
    logic  unused_bits;

    assign aw_addr = s_axi.awaddr;
    assign ar_addr = s_axi.araddr;

    // Protection bits and the non-decoded address bits carry no meaning here
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, aw_addr, ar_addr};

    assign aw_hs = aw_ready & s_axi.awvalid;
    assign w_hs  = w_ready & s_axi.wvalid;
    assign ar_hs = ar_ready & s_axi.arvalid;

    // Write FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // Write FSM next state: collect AW and W in any order, commit, then respond
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_state_nxt = W_COMMIT;
                end else if (aw_hs) begin
                    wr_state_nxt = W_HAVE_ADDR;
                end else if (w_hs) begin
                    wr_state_nxt = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_hs)  wr_state_nxt = W_COMMIT;
            W_HAVE_DATA: if (aw_hs) wr_state_nxt = W_COMMIT;
            W_COMMIT:    wr_state_nxt = W_RESP;
            W_RESP:      if (s_axi.bready) wr_state_nxt = W_IDLE;
            default:     wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs: a channel is ready only while its holding slot is empty
    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        commit   = 1'b0;
        case (wr_state)
            W_IDLE: begin
                aw_ready = S_AXI_ARESETN & s_axi.awvalid;
                w_ready  = S_AXI_ARESETN & s_axi.wvalid;
            end
            W_HAVE_ADDR: w_ready  = S_AXI_ARESETN & s_axi.wvalid;
            W_HAVE_DATA: aw_ready = S_AXI_ARESETN & s_axi.awvalid;
            W_COMMIT:    commit   = 1'b1;
            W_RESP:      b_valid  = 1'b1;
            default: ;
        endcase
    end

    // Holding slots for the captured write address and data
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= ofs_to_idx(aw_addr[3:0]);
            if (w_hs) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
        end
    end

    // Register file: byte-merged update on the commit edge
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[aw_idx_q] <= merge_wstrb(regs[aw_idx_q], wdata_q, wstrb_q);
        end
    end

    // Read FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Read FSM next state: one read in flight until the master takes the data
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_nxt = R_VALID;
            R_VALID: if (s_axi.rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        case (rd_state)
            R_IDLE:  ar_ready = S_AXI_ARESETN & s_axi.arvalid;
            R_VALID: r_valid  = 1'b1;
            default: ;
        endcase
    end

    // Read data is sampled at the AR handshake and held until accepted
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rdata_q <= '0;
        end else if (ar_hs) begin
            rdata_q <= regs[ofs_to_idx(ar_addr[3:0])];
        end
    end

    assign s_axi.awready = aw_ready;
    assign s_axi.wready  = w_ready;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = AXI_RESP_OKAY;
    assign s_axi.arready = ar_ready;
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = AXI_RESP_OKAY;

    assign cur_mode      = mode_e'(regs[MODE_IDX][0]);
    assign blink_restart = commit & ((aw_idx_q == MODE_IDX) | (aw_idx_q == PERIOD_IDX));

    led_blink_gen u_blink (
        .clk     (S_AXI_ACLK),
        .resetn  (S_AXI_ARESETN),
        .enable  (cur_mode == MODE_BLINK),
        .period  (regs[PERIOD_IDX]),
        .restart (blink_restart),
        .phase   (phase)
    );

    // LED drive: static value, or value gated by the blink phase
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            led <= '0;
        end else if (cur_mode == MODE_BLINK) begin
            led <= regs[LED_VAL_IDX][NUM_LEDS-1:0] & {NUM_LEDS{phase}};
        end else begin
            led <= regs[LED_VAL_IDX][NUM_LEDS-1:0];
        end
    end
endmodule

// File: tb/tb_led_ctrl_axil_slave.sv
// Self-checking bench for led_ctrl_axil_slave: directed register, handshake,
// blink and reset scenarios plus a randomized read/write phase, all compared
// against a register-array model kept in the bench.
module tb_led_ctrl_axil_slave;
    import led_ctrl_pkg::*;

    localparam int NUM_LEDS = 4;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic [NUM_LEDS-1:0] led;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] model_regs [4];

    int last_start, last_aw_hs, last_w_hs, last_b_first, last_b_hs;

    led_ctrl_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    led_ctrl_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .NUM_LEDS           (NUM_LEDS)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (resetn),
        .s_axi         (bus),
        .led           (led)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n the value is n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = '0;
    endfunction

    // LED value j clocks after the restarting write commits
    function automatic logic [NUM_LEDS-1:0] blink_expect(input logic [31:0] val, input logic [31:0] per, input int j);
        int p;
        int k;
        p = (per == 0) ? 1 : int'(per);
        k = j - 1;
        if (((k / p) % 2) == 0) return val[NUM_LEDS-1:0];
        return '0;
    endfunction

    function automatic logic [NUM_LEDS-1:0] static_expect();
        logic [31:0] v;
        v = model_regs[0];
        return v[NUM_LEDS-1:0];
    endfunction

    task automatic send_aw(input logic [3:0] addr, input int dly, output int hs);
        int n;
        bit got;
        repeat (dly) begin @(posedge clk); #1; end
        bus.awaddr  = addr;
        bus.awprot  = 3'($urandom);
        bus.awvalid = 1'b1;
        n = 0; got = 0; hs = -1;
        while (!got && n < 64) begin
            @(negedge clk); got = bus.awready;
            @(posedge clk); #1; n++;
        end
        bus.awvalid = 1'b0;
        if (got) hs = cyc;
        else checkOutput("aw_timeout", 32'(got), 32'd1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output int hs);
        int n;
        bit got;
        repeat (dly) begin @(posedge clk); #1; end
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        n = 0; got = 0; hs = -1;
        while (!got && n < 64) begin
            @(negedge clk); got = bus.wready;
            @(posedge clk); #1; n++;
        end
        bus.wvalid = 1'b0;
        if (got) hs = cyc;
        else checkOutput("w_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_b(input int dly, output int first, output int hs, output logic [1:0] resp);
        int n;
        bit done;
        n = 0; done = 0; first = -1; hs = -1; resp = 2'b11;
        bus.bready = (dly == 0);
        while (!done && n < 64) begin
            @(negedge clk);
            if (bus.bvalid && first < 0) first = cyc;
            if (bus.bvalid && bus.bready) begin done = 1; resp = bus.bresp; end
            @(posedge clk); #1; n++;
            if (n >= dly) bus.bready = 1'b1;
        end
        bus.bready = 1'b0;
        if (done) hs = cyc;
        else checkOutput("b_timeout", 32'(done), 32'd1);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int aw_h, w_h, b_f, b_h;
        logic [1:0] resp;
        last_start = cyc;
        fork
            begin send_aw(addr, aw_dly, aw_h); end
            begin send_w(data, strb, w_dly, w_h); end
        join
        wait_b(b_dly, b_f, b_h, resp);
        last_aw_hs = aw_h; last_w_hs = w_h; last_b_first = b_f; last_b_hs = b_h;
        checkOutput("bresp", 32'(resp), 32'(AXI_RESP_OKAY));
        checkOutput("b_after_hs", 32'(b_f), 32'(((aw_h > w_h) ? aw_h : w_h) + 1));
        model_write(addr, data, strb);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] expected, input int r_dly, input string tag);
        int n, ar_h, r_f, bad_hold;
        bit got, done;
        logic [31:0] data;
        logic [1:0]  resp;
        bus.araddr  = addr;
        bus.arprot  = 3'($urandom);
        bus.arvalid = 1'b1;
        n = 0; got = 0;
        while (!got && n < 64) begin
            @(negedge clk); got = bus.arready;
            @(posedge clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        ar_h = cyc;
        if (!got) checkOutput("ar_timeout", 32'(got), 32'd1);
        bus.rready = (r_dly == 0);
        n = 0; done = 0; r_f = -1; bad_hold = 0; data = 32'hDEAD_BEEF; resp = 2'b11;
        while (!done && n < 64) begin
            @(negedge clk);
            if (bus.rvalid) begin
                if (r_f < 0) r_f = cyc;
                if (bus.rdata !== expected) bad_hold++;
                if (bus.rready) begin done = 1; data = bus.rdata; resp = bus.rresp; end
            end
            @(posedge clk); #1; n++;
            if (n >= r_dly) bus.rready = 1'b1;
        end
        bus.rready = 1'b0;
        if (!done) checkOutput("r_timeout", 32'(done), 32'd1);
        checkOutput(tag, data, expected);
        checkOutput("rresp", 32'(resp), 32'(AXI_RESP_OKAY));
        checkOutput("r_latency", 32'(r_f - ar_h), 32'd0);
        if (r_dly > 0) checkOutput("rdata_hold", 32'(bad_hold), 32'd0);
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), model_regs[i], $urandom_range(0, 2), tag);
        end
    endtask

    task automatic applyStimulus(input int iters);
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        for (int it = 0; it < iters; it++) begin
            addr = {2'($urandom), 2'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom);
                axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                if (model_regs[1][0] == 1'b0) begin
                    checkOutput("rand_led", 32'(led), 32'(static_expect()));
                end
            end else begin
                axi_read(addr, model_regs[int'(addr) / 4], $urandom_range(0, 3), "rand_rdata");
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int aw_h, w_h, b_f, b_h, held, blocked, stale, e;
        logic [1:0]  resp;
        logic [31:0] val, per, old_val;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        model_reset();

        // Reset with every VALID asserted: nothing may be accepted
        resetn = 1'b0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_awready", 32'(bus.awready), 32'd0);
        checkOutput("rst_wready",  32'(bus.wready),  32'd0);
        checkOutput("rst_arready", 32'(bus.arready), 32'd0);
        checkOutput("rst_bvalid",  32'(bus.bvalid),  32'd0);
        checkOutput("rst_rvalid",  32'(bus.rvalid),  32'd0);
        checkOutput("rst_rdata",   bus.rdata,        32'd0);
        checkOutput("rst_led",     32'(led),         32'd0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        resetn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Basic register writes and read-back
        axi_write(LED_VAL_OFS, 32'h1, 4'hF, 0, 0, 0);
        checkOutput("b_latency", 32'(last_b_first - last_start), 32'd2);
        axi_write(MODE_OFS,    32'h2, 4'hF, 0, 0, 0);
        axi_write(PERIOD_OFS,  32'h3, 4'hF, 0, 0, 0);
        axi_write(SCRATCH_OFS, 32'h4, 4'hF, 0, 0, 0);
        checkOutput("static_led", 32'(led), 32'h1);
        read_all("basic_rdata");

        // AW three clocks ahead of W, then W three clocks ahead of AW
        axi_write(SCRATCH_OFS, 32'hCAFE_0001, 4'hF, 0, 3, 1);
        checkOutput("aw_first_gap", 32'(last_w_hs - last_aw_hs), 32'd3);
        axi_write(PERIOD_OFS, 32'h0000_0007, 4'hF, 3, 0, 2);
        checkOutput("w_first_gap", 32'(last_aw_hs - last_w_hs), 32'd3);
        read_all("order_rdata");

        // Byte strobe merge
        axi_write(SCRATCH_OFS, 32'h1122_3344, 4'hF, 0, 0, 0);
        axi_write(SCRATCH_OFS, 32'hAABB_CCDD, 4'b0010, 0, 0, 0);
        axi_read(SCRATCH_OFS, 32'h1122_CC44, 0, "wstrb_merge");

        // Read landing on the same edge as a write to that register sees the old value
        old_val = model_regs[3];
        fork
            begin axi_write(SCRATCH_OFS, 32'h5555_AAAA, 4'hF, 0, 0, 0); end
            begin @(posedge clk); #1; axi_read(SCRATCH_OFS, old_val, 0, "rw_old_value"); end
        join
        axi_read(SCRATCH_OFS, 32'h5555_AAAA, 0, "rw_new_value");

        // BREADY held low: B stays up and a second AW is refused
        fork
            begin send_aw(LED_VAL_OFS, 0, aw_h); end
            begin send_w(32'h0000_0005, 4'hF, 0, w_h); end
        join
        bus.bready = 1'b0;
        @(posedge clk); #1;
        bus.awaddr = SCRATCH_OFS; bus.awvalid = 1'b1;
        held = 0; blocked = 0;
        repeat (5) begin
            @(negedge clk);
            held    += int'(bus.bvalid);
            blocked += int'(bus.awready);
            @(posedge clk); #1;
        end
        checkOutput("b_held", 32'(held), 32'd5);
        checkOutput("aw_blocked", 32'(blocked), 32'd0);
        fork
            begin send_aw(SCRATCH_OFS, 0, aw_h); end
            begin wait_b(0, b_f, b_h, resp); end
        join
        checkOutput("aw_after_b", 32'(aw_h - b_h), 32'd1);
        model_write(LED_VAL_OFS, 32'h0000_0005, 4'hF);
        send_w(32'h0BAD_F00D, 4'hF, 0, w_h);
        wait_b(0, b_f, b_h, resp);
        checkOutput("b2_after_w", 32'(b_f - w_h), 32'd1);
        model_write(SCRATCH_OFS, 32'h0BAD_F00D, 4'hF);
        axi_read(LED_VAL_OFS, model_regs[0], 0, "b_hold_rdata0");
        axi_read(SCRATCH_OFS, model_regs[3], 0, "b_hold_rdata3");

        // Blink: fixed cases first, then random values and periods
        for (int t = 0; t < 6; t++) begin
            per = (t == 0) ? 32'd3 : (t == 1) ? 32'd0 : 32'($urandom_range(0, 5));
            val = (t < 2) ? 32'hF : $urandom;
            axi_write(LED_VAL_OFS, val, 4'hF, 0, 0, 0);
            axi_write(PERIOD_OFS, per, 4'hF, 0, 0, 0);
            axi_write(MODE_OFS, 32'h1, 4'hF, 0, 0, 0);
            e = last_b_first;
            repeat (14) begin
                @(negedge clk);
                checkOutput("blink_led", 32'(led), 32'(blink_expect(val, per, cyc - e)));
                @(posedge clk); #1;
            end
        end
        per = 32'd2;
        axi_write(PERIOD_OFS, per, 4'hF, 0, 0, 0);
        e = last_b_first;
        repeat (10) begin
            @(negedge clk);
            checkOutput("period_restart_led", 32'(led), 32'(blink_expect(val, per, cyc - e)));
            @(posedge clk); #1;
        end
        axi_write(MODE_OFS, 32'h0, 4'hF, 0, 0, 0);
        @(negedge clk);
        checkOutput("back_to_static", 32'(led), 32'(static_expect()));
        @(posedge clk); #1;

        // Randomized mix of reads and writes
        applyStimulus(40);
        read_all("rand_final");

        // Reset while a write response is pending
        axi_write(LED_VAL_OFS, 32'h0000_000A, 4'hF, 0, 0, 0);
        axi_write(MODE_OFS, 32'h0, 4'hF, 0, 0, 0);
        fork
            begin send_aw(PERIOD_OFS, 0, aw_h); end
            begin send_w(32'h0000_0009, 4'hF, 0, w_h); end
        join
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        checkOutput("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
        checkOutput("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
        checkOutput("mid_rst_awready", 32'(bus.awready), 32'd0);
        checkOutput("mid_rst_rdata",   bus.rdata,        32'd0);
        checkOutput("mid_rst_led",     32'(led),         32'd0);
        @(posedge clk); #1;
        bus.bready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            stale += int'(bus.bvalid);
            @(posedge clk); #1;
        end
        bus.bready = 1'b0;
        checkOutput("stale_b", 32'(stale), 32'd0);
        read_all("post_rst_rdata");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
